// File: rtl/exec_seq_ctrl_pkg.sv
// Shared definitions for the execute/memory/writeback sequencer: RV32I/RV64I opcode and
// funct3 encodings, sequencer states, trap cause codes and the branch condition helper.
package exec_seq_ctrl_pkg;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpOp32    = 7'b0111011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;

  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;
  localparam logic [2:0] F3Sd = 3'b011;

  typedef enum logic [2:0] {
    StIdle, StExec, StAluWait, StMem, StWb, StTrap
  } state_e;

  typedef enum logic [1:0] {
    CauseIllegal    = 2'd0,
    CauseMisaligned = 2'd1,
    CauseTimeout    = 2'd2
  } trap_cause_e;

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3Beq:   taken = eq;
      F3Bne:   taken = !eq;
      F3Blt:   taken = lt;
      F3Bge:   taken = !lt;
      F3Bltu:  taken = ltu;
      F3Bgeu:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/exec_seq_ctrl_if.sv
// Bundle of every sequencer-facing signal except clock and reset: instruction issue,
// ALU handshake, data memory, register writeback, PC redirect and retire/trap.
//   master: the sequencer (drives issue_ready, alu_start, mem_*, rd_*, redirect, done/trap)
//   slave : the surrounding core/memory model (drives issue fields, ALU and memory replies)
interface exec_seq_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rd_addr;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   pc_val;
  logic              alu_start;
  logic              alu_done;
  logic [XLEN-1:0]   alu_result;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;
  logic              rd_we;
  logic [4:0]        rd_waddr;
  logic [XLEN-1:0]   rd_wdata;
  logic              j_signal;
  logic [XLEN-1:0]   jump_target;
  logic              done;
  logic              trap;
  logic [1:0]        trap_cause;

  modport master (
    input  issue_valid, opcode, funct3, rd_addr, rs1_val, rs2_val, imm, pc_val,
           alu_done, alu_result, mem_rdata, mem_ready,
    output issue_ready, alu_start, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           rd_we, rd_waddr, rd_wdata, j_signal, jump_target, done, trap, trap_cause
  );

  modport slave (
    output issue_valid, opcode, funct3, rd_addr, rs1_val, rs2_val, imm, pc_val,
           alu_done, alu_result, mem_rdata, mem_ready,
    input  issue_ready, alu_start, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           rd_we, rd_waddr, rd_wdata, j_signal, jump_target, done, trap, trap_cause
  );
endinterface

// File: rtl/exec_seq_ctrl_lsu_align.sv
// Combinational load/store lane alignment.
//   funct3     : load/store size/sign encoding
//   offset     : byte offset of the access within the XLEN-wide word
//   store_data : rs2 value; replicated into every lane as wdata, with wstrb selecting lanes
//   load_raw   : memory read word; load_data is the selected lane, sign/zero-extended
module exec_seq_ctrl_lsu_align
  import exec_seq_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]               funct3,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [XLEN-1:0]          store_data,
  input  logic [XLEN-1:0]          load_raw,
  output logic [XLEN-1:0]          wdata,
  output logic [XLEN/8-1:0]        wstrb,
  output logic [XLEN-1:0]          load_data
);
  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] shifted;

  always_comb begin
    wdata = '0;
    wstrb = '0;
    unique case (funct3[1:0])
      2'b00: begin
        wdata = {NB{store_data[7:0]}};
        wstrb = NB'(1) << offset;
      end
      2'b01: begin
        wdata = {(NB/2){store_data[15:0]}};
        wstrb = NB'(3) << offset;
      end
      2'b10: begin
        wdata = {(NB/4){store_data[31:0]}};
        wstrb = NB'(15) << offset;
      end
      default: begin
        wdata = store_data;
        wstrb = '1;
      end
    endcase
  end

  always_comb begin
    shifted   = load_raw >> {offset, 3'b000};
    load_data = shifted;
    case (funct3)
      F3Lb:    load_data = XLEN'($signed(shifted[7:0]));
      F3Lh:    load_data = XLEN'($signed(shifted[15:0]));
      F3Lw:    load_data = XLEN'($signed(shifted[31:0]));
      F3Lbu:   load_data = XLEN'(shifted[7:0]);
      F3Lhu:   load_data = XLEN'(shifted[15:0]);
      F3Lwu:   load_data = XLEN'(shifted[31:0]);
      default: load_data = shifted;
    endcase
  end
endmodule

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle execute/memory/writeback sequencer. Latches one issued instruction, drives
// the ALU or data memory as needed, then retires it (done) or traps.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : exec_seq_ctrl_if master port (issue, ALU, memory, writeback, redirect)
module exec_seq_ctrl
  import exec_seq_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  exec_seq_ctrl_if.master bus
);
  localparam int unsigned OffW    = $clog2(XLEN / 8);
  localparam int unsigned CntW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [6:0]        opcode_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, imm_q, pc_q;
  logic [XLEN-1:0]   wdata_q, target_q, addr_q;
  logic              jump_q;
  trap_cause_e       cause_q;
  logic [CntW-1:0]   cnt_q;

  logic              hs, legal, is_alu, is_mem, is_store, writes_rd, misaligned, timeout;
  logic              exec_jump;
  logic [XLEN-1:0]   sum_addr, exec_wdata, exec_target, pc_plus4;
  logic [XLEN-1:0]   lsu_wdata, lsu_load;
  logic [XLEN/8-1:0] lsu_wstrb;

  assign hs       = bus.issue_valid && (state_q == StIdle);
  assign sum_addr = rs1_q + imm_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign timeout  = (MEM_TIMEOUT != 0) && (cnt_q == CntLast);

  // Decode of the latched instruction.
  always_comb begin
    legal     = 1'b0;
    is_alu    = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    case (opcode_q)
      OpOp, OpOpImm: begin
        legal = 1'b1; is_alu = 1'b1; writes_rd = 1'b1;
      end
      OpOp32, OpOpImm32: begin
        legal = (XLEN == 64); is_alu = 1'b1; writes_rd = 1'b1;
      end
      OpLui, OpAuipc, OpJal: begin
        legal = 1'b1; writes_rd = 1'b1;
      end
      OpJalr: begin
        legal = (funct3_q == 3'b000); writes_rd = 1'b1;
      end
      OpBranch: legal = (funct3_q[2:1] != 2'b01);
      OpLoad: begin
        is_mem = 1'b1; writes_rd = 1'b1;
        legal  = (funct3_q inside {F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu}) ||
                 ((XLEN == 64) && (funct3_q inside {F3Ld, F3Lwu}));
      end
      OpStore: begin
        is_mem = 1'b1; is_store = 1'b1;
        legal  = (funct3_q inside {F3Sb, F3Sh, F3Sw}) || ((XLEN == 64) && (funct3_q == F3Sd));
      end
      default: ;
    endcase
  end

  // Non-ALU results and redirect decision, captured at the end of EXEC.
  always_comb begin
    exec_wdata  = '0;
    exec_target = pc_q + imm_q;
    exec_jump   = 1'b0;
    case (opcode_q)
      OpLui:   exec_wdata = imm_q;
      OpAuipc: exec_wdata = pc_q + imm_q;
      OpJal: begin
        exec_wdata = pc_plus4; exec_jump = 1'b1;
      end
      OpJalr: begin
        exec_wdata  = pc_plus4; exec_jump = 1'b1;
        exec_target = {sum_addr[XLEN-1:1], 1'b0};
      end
      OpBranch: exec_jump = branch_taken(funct3_q, rs1_q == rs2_q,
                                         $signed(rs1_q) < $signed(rs2_q), rs1_q < rs2_q);
      default: ;
    endcase
  end

  always_comb begin
    unique case (funct3_q[1:0])
      2'b01:   misaligned = sum_addr[0];
      2'b10:   misaligned = |sum_addr[1:0];
      2'b11:   misaligned = |sum_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (hs) state_d = StExec;
      StExec: begin
        if (!legal)                    state_d = StTrap;
        else if (is_alu)               state_d = StAluWait;
        else if (is_mem && misaligned) state_d = StTrap;
        else if (is_mem)               state_d = StMem;
        else                           state_d = StWb;
      end
      StAluWait: if (bus.alu_done) state_d = StWb;
      StMem: begin
        if (bus.mem_ready)  state_d = StWb;
        else if (timeout)   state_d = StTrap;
      end
      StWb, StTrap: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      addr_q   <= '0;
      jump_q   <= 1'b0;
      cause_q  <= CauseIllegal;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        opcode_q <= bus.opcode;
        funct3_q <= bus.funct3;
        rd_q     <= bus.rd_addr;
        rs1_q    <= bus.rs1_val;
        rs2_q    <= bus.rs2_val;
        imm_q    <= bus.imm;
        pc_q     <= bus.pc_val;
      end
      if (state_q == StExec) begin
        wdata_q  <= exec_wdata;
        target_q <= exec_target;
        jump_q   <= exec_jump;
        addr_q   <= sum_addr;
        cause_q  <= legal ? CauseMisaligned : CauseIllegal;
        cnt_q    <= '0;
      end
      if (state_q == StAluWait && bus.alu_done) wdata_q <= bus.alu_result;
      if (state_q == StMem) begin
        cause_q <= CauseTimeout;
        if (bus.mem_ready) wdata_q <= lsu_load;
        else               cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  exec_seq_ctrl_lsu_align #(
    .XLEN (XLEN)
  ) u_lsu_align (
    .funct3     (funct3_q),
    .offset     (addr_q[OffW-1:0]),
    .store_data (rs2_q),
    .load_raw   (bus.mem_rdata),
    .wdata      (lsu_wdata),
    .wstrb      (lsu_wstrb),
    .load_data  (lsu_load)
  );

  // Outputs decode purely from state so an asynchronous reset silences them at once.
  always_comb begin
    bus.issue_ready = (state_q == StIdle);
    bus.alu_start   = (state_q == StExec) && legal && is_alu;
    bus.mem_req     = (state_q == StMem);
    bus.mem_we      = bus.mem_req && is_store;
    bus.mem_addr    = bus.mem_req ? addr_q : '0;
    bus.mem_wdata   = bus.mem_we ? lsu_wdata : '0;
    bus.mem_wstrb   = bus.mem_we ? lsu_wstrb : '0;
    bus.rd_we       = (state_q == StWb) && writes_rd && (rd_q != 5'd0);
    bus.rd_waddr    = bus.rd_we ? rd_q : '0;
    bus.rd_wdata    = bus.rd_we ? wdata_q : '0;
    bus.j_signal    = (state_q == StWb) && jump_q;
    bus.jump_target = bus.j_signal ? target_q : '0;
    bus.done        = (state_q == StWb);
    bus.trap        = (state_q == StTrap);
    bus.trap_cause  = bus.trap ? cause_q : 2'd0;
  end
endmodule

// File: tb/tb_exec_seq_ctrl.sv
module tb_exec_seq_ctrl;
  import exec_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_seq_ctrl_if #(.XLEN(32)) bus ();

  exec_seq_ctrl #(
    .XLEN        (32),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observations from the most recent run_op.
  int          res_req, res_lat, res_alu;
  logic        res_unstable, res_we, res_rd_we, res_j, res_done, res_trap;
  logic [31:0] res_addr, res_wdata, res_rd_wdata, res_target;
  logic [3:0]  res_wstrb;
  logic [4:0]  res_rd_waddr;
  logic [1:0]  res_cause;

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                        input logic [31:0] pc, input int mem_wait, input logic [31:0] rdata,
                        input logic [31:0] alu_res);
    res_req = 0; res_lat = 0; res_alu = 0; res_unstable = 0; res_we = 0; res_rd_we = 0;
    res_j = 0; res_done = 0; res_trap = 0; res_addr = 0; res_wdata = 0; res_rd_wdata = 0;
    res_target = 0; res_wstrb = 0; res_rd_waddr = 0; res_cause = 0;
    @(negedge clk);
    bus.opcode = op; bus.funct3 = f3; bus.rd_addr = rd; bus.rs1_val = r1; bus.rs2_val = r2;
    bus.imm = im; bus.pc_val = pc; bus.issue_valid = 1'b1;
    @(negedge clk);
    // Scramble the issue fields; the DUT must be working from its latched copy.
    bus.issue_valid = 1'b0;
    bus.opcode = 7'h7f; bus.funct3 = ~f3; bus.rd_addr = ~rd; bus.rs1_val = ~r1;
    bus.rs2_val = ~r2; bus.imm = ~im; bus.pc_val = ~pc;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.alu_start) begin
        res_alu++;
        bus.alu_done = 1'b1;
        bus.alu_result = alu_res;
      end
      if (bus.mem_req) begin
        res_req++;
        if (res_req == 1) begin
          res_addr = bus.mem_addr; res_wstrb = bus.mem_wstrb;
          res_wdata = bus.mem_wdata; res_we = bus.mem_we;
        end else if (bus.mem_addr !== res_addr || bus.mem_wstrb !== res_wstrb ||
                     bus.mem_wdata !== res_wdata || bus.mem_we !== res_we) begin
          res_unstable = 1'b1;
        end
        bus.mem_ready = (res_req == mem_wait + 1);
        bus.mem_rdata = rdata;
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (bus.rd_we) begin
        res_rd_we = 1'b1; res_rd_waddr = bus.rd_waddr; res_rd_wdata = bus.rd_wdata;
      end
      if (bus.j_signal) begin
        res_j = 1'b1; res_target = bus.jump_target;
      end
      if (bus.done || bus.trap) begin
        res_done = bus.done; res_trap = bus.trap; res_cause = bus.trap_cause; res_lat = k;
        break;
      end
    end
    bus.alu_done = 1'b0;
    bus.mem_ready = 1'b0;
    check("op.finished", {31'd0, res_done | res_trap}, 32'd1);
  endtask

  initial begin
    logic seen;
    bus.issue_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.rd_addr = '0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.imm = '0; bus.pc_val = '0;
    bus.alu_done = 1'b0; bus.alu_result = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;

    #1;
    check("rst.issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    check("rst.mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst.alu_start", {31'd0, bus.alu_start}, 32'd0);
    check("rst.done_trap_rdwe", {29'd0, bus.done, bus.trap, bus.rd_we}, 32'd0);
    check("rst.wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // sw, three wait states
    run_op(OpStore, F3Sw, 5'd0, 32'h100, 32'hDEADBEEF, 32'd4, 32'h0, 3, 32'h0, 32'h0);
    check("sw.addr", res_addr, 32'h104);
    check("sw.wstrb", {28'd0, res_wstrb}, 32'hF);
    check("sw.wdata", res_wdata, 32'hDEADBEEF);
    check("sw.we", {31'd0, res_we}, 32'd1);
    check("sw.req_cycles", res_req, 32'd4);
    check("sw.stable", {31'd0, res_unstable}, 32'd0);
    check("sw.done", {31'd0, res_done}, 32'd1);
    check("sw.rd_we", {31'd0, res_rd_we}, 32'd0);
    check("sw.latency", res_lat, 32'd6);

    // sb at byte 1: strobe 0010, byte replicated
    run_op(OpStore, F3Sb, 5'd0, 32'h100, 32'h000000AB, 32'd1, 32'h0, 0, 32'h0, 32'h0);
    check("sb.wstrb", {28'd0, res_wstrb}, 32'h2);
    check("sb.wdata", res_wdata, 32'hABABABAB);

    // lb / lbu from byte 3
    run_op(OpLoad, F3Lb, 5'd5, 32'h200, 32'h0, 32'd3, 32'h0, 0, 32'h80123456, 32'h0);
    check("lb.addr", res_addr, 32'h203);
    check("lb.we", {31'd0, res_we}, 32'd0);
    check("lb.rd_wdata", res_rd_wdata, 32'hFFFFFF80);
    check("lb.rd_waddr", {27'd0, res_rd_waddr}, 32'd5);
    check("lb.latency", res_lat, 32'd3);
    run_op(OpLoad, F3Lbu, 5'd5, 32'h200, 32'h0, 32'd3, 32'h0, 0, 32'h80123456, 32'h0);
    check("lbu.rd_wdata", res_rd_wdata, 32'h00000080);

    // signed vs unsigned branch on the same operands
    run_op(OpBranch, F3Blt, 5'd7, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 0, 32'h0, 32'h0);
    check("blt.taken", {31'd0, res_j}, 32'd1);
    check("blt.target", res_target, 32'h120);
    check("blt.rd_we", {31'd0, res_rd_we}, 32'd0);
    check("blt.latency", res_lat, 32'd2);
    run_op(OpBranch, F3Bltu, 5'd7, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 0, 32'h0, 32'h0);
    check("bltu.taken", {31'd0, res_j}, 32'd0);
    check("bltu.rd_we", {31'd0, res_rd_we}, 32'd0);
    check("bltu.done", {31'd0, res_done}, 32'd1);

    // jalr with bit0 cleared, then rd=0
    run_op(OpJalr, 3'b000, 5'd1, 32'h1001, 32'h0, 32'd2, 32'h40, 0, 32'h0, 32'h0);
    check("jalr.target", res_target, 32'h1002);
    check("jalr.rd_wdata", res_rd_wdata, 32'h44);
    check("jalr.rd_we", {31'd0, res_rd_we}, 32'd1);
    run_op(OpJalr, 3'b000, 5'd0, 32'h1001, 32'h0, 32'd2, 32'h40, 0, 32'h0, 32'h0);
    check("jalr0.rd_we", {31'd0, res_rd_we}, 32'd0);
    check("jalr0.j", {31'd0, res_j}, 32'd1);

    // jal at all-ones PC: link wraps to 3
    run_op(OpJal, 3'b000, 5'd2, 32'h0, 32'h0, 32'h10, 32'hFFFFFFFF, 0, 32'h0, 32'h0);
    check("jal.rd_wdata", res_rd_wdata, 32'h3);
    check("jal.target", res_target, 32'hF);

    // lui and ALU op
    run_op(OpLui, 3'b000, 5'd3, 32'h0, 32'h0, 32'hABCDE000, 32'h0, 0, 32'h0, 32'h0);
    check("lui.rd_wdata", res_rd_wdata, 32'hABCDE000);
    run_op(OpOp, 3'b000, 5'd9, 32'h1, 32'h2, 32'h0, 32'h0, 0, 32'h0, 32'h12345678);
    check("add.alu_start", res_alu, 32'd1);
    check("add.rd_wdata", res_rd_wdata, 32'h12345678);
    check("add.latency", res_lat, 32'd3);

    // traps
    run_op(OpLoad, F3Lw, 5'd4, 32'h100, 32'h0, 32'd2, 32'h0, 0, 32'h0, 32'h0);
    check("lw_mis.trap", {31'd0, res_trap}, 32'd1);
    check("lw_mis.cause", {30'd0, res_cause}, 32'd1);
    check("lw_mis.req", res_req, 32'd0);
    check("lw_mis.rd_we", {31'd0, res_rd_we}, 32'd0);
    run_op(OpLoad, F3Lw, 5'd4, 32'h100, 32'h0, 32'd0, 32'h0, 1000, 32'h0, 32'h0);
    check("lw_to.trap", {31'd0, res_trap}, 32'd1);
    check("lw_to.cause", {30'd0, res_cause}, 32'd2);
    check("lw_to.req", res_req, 32'd8);
    check("lw_to.latency", res_lat, 32'd10);
    run_op(7'h7f, 3'b000, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    check("illegal.trap", {31'd0, res_trap}, 32'd1);
    check("illegal.cause", {30'd0, res_cause}, 32'd0);

    // reset during a memory wait
    @(negedge clk);
    bus.opcode = OpStore; bus.funct3 = F3Sw; bus.rd_addr = 5'd0; bus.rs1_val = 32'h100;
    bus.rs2_val = 32'h5; bus.imm = 32'h0; bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid.req_before", {31'd0, bus.mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid.req", {31'd0, bus.mem_req}, 32'd0);
    check("rstmid.issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done || bus.trap || bus.mem_req) seen = 1'b1;
    end
    check("rstmid.no_retire", {31'd0, seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
